fetch: RTL and testbench
========================

Name: fetch

Overview:
- Fetch stage of the sequential Y86-64 processor.
- Receives the current PC and a 10-byte instruction window read from instruction memory starting at PC.
- Splits the window into icode, ifun, rA, rB and valC, computes the next sequential PC (valP), and flags invalid memory or invalid instructions.
- Field decode is combinational. A single sticky halt register is the only clocked state.

Parameters:
- MEM_SIZE, 65536: instruction memory size in bytes. A PC at or above this value is out of range.

Ports:
- clk  input  1  system clock; only the halt register uses it
- reset  input  1  asynchronous, active-high; clears the halt register
- PC  input  64  address of the current instruction
- instruction  input  80  bytes M[PC]..M[PC+9]; bit 0 (MSB, declared [0:79]) is the MSB of M[PC]
- icode  output  4  upper nibble of byte 0
- ifun  output  4  lower nibble of byte 0
- rA  output  4  upper nibble of byte 1, or 4'hF when the instruction has no register byte
- rB  output  4  lower nibble of byte 1, or 4'hF when the instruction has no register byte
- valC  output  64  constant word, or 0 when the instruction has none
- valP  output  64  next sequential PC
- valid_memory  output  1  1 when PC < MEM_SIZE
- valid_instruction  output  1  1 when icode/ifun is a legal encoding
- halted  output  1  registered sticky halt flag

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Combinational outputs: all outputs except halted are purely combinational from PC, instruction and halted, with zero latency.
- Byte N of the window: instruction[8N : 8N+7].
- Multi-byte constants are big-endian: the lowest-addressed byte is the most significant.
- Per-icode decode (register byte / valC source / length in bytes):
  - 0 halt: none / none / 1
  - 1 nop: none / none / 1
  - 2 cmovXX: yes / none / 2
  - 3 irmovq: yes / bytes 2-9 / 10
  - 4 rmmovq: yes / bytes 2-9 / 10
  - 5 mrmovq: yes / bytes 2-9 / 10
  - 6 OPq: yes / none / 2
  - 7 jXX: none / bytes 1-8 / 9
  - 8 call: none / bytes 1-8 / 9
  - 9 ret: none / none / 1
  - A pushq: yes / none / 2
  - B popq: yes / none / 2
- valid_instruction = 0 when any of these holds:
  - icode > 4'hB
  - icode 2 or 7 with ifun > 6
  - icode 6 with ifun > 3
- ifun of all other icodes is not checked; pushq/popq with ifun=1 are valid.
- valid_memory = (PC < MEM_SIZE). An out-of-range PC forces valid_instruction = 0.
- icode and ifun always show the raw nibbles, even when the instruction is invalid.
- valP = PC + length, with 64-bit wrap-around.
- valP = PC (fetch stalls) in any of these cases:
  - instruction invalid
  - memory invalid
  - icode = 0 (halt)
  - halted = 1
- Halt register:
  - On posedge clk, if icode = 0 and the instruction and memory are both valid, halted becomes 1.
  - Once set, halted stays set until reset.
  - reset asserted at any time clears halted to 0 immediately. After reset deasserts, normal decode resumes at the next edge.
- Reset value: halted = 0. Combinational outputs follow their inputs during reset.

Test Plan:
- reset pulse, then PC=64 with bytes 20 23 → icode=2 ifun=0 rA=2 rB=3 valC=0 valP=66; PC=96 bytes 63 24 → icode=6 ifun=3 rA=2 rB=4 valP=98.
- PC=66 bytes 30 F3 00×7 1F → rA=F rB=3 valC=31 valP=76; PC=76 bytes 40 24 00×7 05 → valC=5 valP=86; PC=86 bytes 50 24 00×7 04 → valC=4 valP=96.
- PC=98 bytes A1 2F → icode=A rA=2 rB=F valP=100 valid_instruction=1; PC=100 bytes B1 2F → valP=102; PC=102 byte 10 → valP=103; 70 followed by 8-byte value 0x40 → valC=64 valP=PC+9.
- Loop PC<=valP on clk from 64: sequence 64,66,76,86,96,98,100,102,103. At PC=103 (byte 00) valP=103, and halted=1 after the next edge. Assert reset → halted=0 asynchronously.
- Illegal encodings: byte C0 → valid_instruction=0, valP=PC; byte 27 → invalid; byte 64 → invalid.
- PC=65536 → valid_memory=0, valid_instruction=0, valP=PC, halted unchanged.

Source files
------------

// File: rtl/fetch.sv
// fetch: Y86-64 sequential fetch stage; combinational field split and next-PC,
// plus a sticky halt flag set when a valid halt instruction is clocked.
module fetch #(
  parameter logic [63:0] MEM_SIZE = 64'd65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PC,
  input  logic [0:79] instruction,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        valid_memory,
  output logic        valid_instruction,
  output logic        halted
);
  logic       has_reg;
  logic       has_c9;
  logic       has_c8;
  logic       bad_enc;
  logic [3:0] len;
  always_comb begin
    icode             = instruction[0:3];
    ifun              = instruction[4:7];
    has_reg           = icode == 4'h2 || (icode >= 4'h3 && icode <= 4'h6) || icode == 4'hA || icode == 4'hB;
    has_c9            = icode >= 4'h3 && icode <= 4'h5;
    has_c8            = icode == 4'h7 || icode == 4'h8;
    bad_enc           = icode > 4'hB || ((icode == 4'h2 || icode == 4'h7) && ifun > 4'h6) || (icode == 4'h6 && ifun > 4'h3);
    rA                = has_reg ? instruction[8:11] : 4'hF;
    rB                = has_reg ? instruction[12:15] : 4'hF;
    valC              = has_c9 ? instruction[16:79] : has_c8 ? instruction[8:71] : 64'd0;
    len               = has_c9 ? 4'd10 : has_c8 ? 4'd9 : has_reg ? 4'd2 : 4'd1;
    valid_memory      = PC < MEM_SIZE;
    valid_instruction = valid_memory && !bad_enc;
    valP              = (!valid_instruction || icode == 4'h0 || halted) ? PC : PC + {60'd0, len};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) halted <= 1'b0;
    else if (icode == 4'h0 && valid_instruction) halted <= 1'b1;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed self-checking bench for the fetch stage.
module tb_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PC;
  logic [0:79] instruction;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        valid_memory, valid_instruction, halted;
  int total = 0;
  int bad = 0;

  fetch dut (
    .clk(clk), .reset(reset), .PC(PC), .instruction(instruction),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .valid_memory(valid_memory), .valid_instruction(valid_instruction), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [145:0] obs();
    return {icode, ifun, rA, rB, valC, valP, valid_memory, valid_instruction};
  endfunction

  function automatic logic [145:0] ex(input logic [3:0] ic, fn, ra, rb, input logic [63:0] c, p, input logic vm, vi);
    return {ic, fn, ra, rb, c, p, vm, vi};
  endfunction

  task automatic drive(input logic [63:0] pc, input logic [79:0] w);
    PC = pc;
    instruction = w;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PC = 64'd0;
    instruction = 80'h10000000000000000000;
    #2;
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reg_ops();
    logic [63:0]  pcs[4];
    logic [79:0]  ws[4];
    logic [145:0] xs[4];
    pcs[0] = 64'd64;  ws[0] = 80'h20230000000000000000; xs[0] = ex(4'h2, 4'h0, 4'h2, 4'h3, 64'd0, 64'd66, 1, 1);
    pcs[1] = 64'd96;  ws[1] = 80'h63240000000000000000; xs[1] = ex(4'h6, 4'h3, 4'h2, 4'h4, 64'd0, 64'd98, 1, 1);
    pcs[2] = 64'd500; ws[2] = 80'h2645FFFFFFFFFFFFFFFF; xs[2] = ex(4'h2, 4'h6, 4'h4, 4'h5, 64'd0, 64'd502, 1, 1);
    pcs[3] = 64'd510; ws[3] = 80'h6017AAAAAAAAAAAAAAAA; xs[3] = ex(4'h6, 4'h0, 4'h1, 4'h7, 64'd0, 64'd512, 1, 1);
    for (int i = 0; i < 4; i++) begin
      drive(pcs[i], ws[i]);
      total++;
      if (obs() !== xs[i]) begin bad++; $display("FAIL reg_op%0d got=%h want=%h", i, obs(), xs[i]); end
    end
  endtask

  task automatic test_const_ops();
    logic [63:0]  pcs[4];
    logic [79:0]  ws[4];
    logic [145:0] xs[4];
    pcs[0] = 64'd66;  ws[0] = 80'h30F3000000000000001F; xs[0] = ex(4'h3, 4'h0, 4'hF, 4'h3, 64'd31, 64'd76, 1, 1);
    pcs[1] = 64'd76;  ws[1] = 80'h40240000000000000005; xs[1] = ex(4'h4, 4'h0, 4'h2, 4'h4, 64'd5, 64'd86, 1, 1);
    pcs[2] = 64'd86;  ws[2] = 80'h50240000000000000004; xs[2] = ex(4'h5, 4'h0, 4'h2, 4'h4, 64'd4, 64'd96, 1, 1);
    pcs[3] = 64'd600; ws[3] = 80'h30F30123456789ABCDEF; xs[3] = ex(4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'd610, 1, 1);
    for (int i = 0; i < 4; i++) begin
      drive(pcs[i], ws[i]);
      total++;
      if (obs() !== xs[i]) begin bad++; $display("FAIL const_op%0d got=%h want=%h", i, obs(), xs[i]); end
    end
  endtask

  task automatic test_stack_jump();
    logic [63:0]  pcs[6];
    logic [79:0]  ws[6];
    logic [145:0] xs[6];
    pcs[0] = 64'd98;  ws[0] = 80'hA12F0000000000000000; xs[0] = ex(4'hA, 4'h1, 4'h2, 4'hF, 64'd0, 64'd100, 1, 1);
    pcs[1] = 64'd100; ws[1] = 80'hB12F0000000000000000; xs[1] = ex(4'hB, 4'h1, 4'h2, 4'hF, 64'd0, 64'd102, 1, 1);
    pcs[2] = 64'd102; ws[2] = 80'h10FFFFFFFFFFFFFFFFFF; xs[2] = ex(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd103, 1, 1);
    pcs[3] = 64'd200; ws[3] = 80'h70000000000000004000; xs[3] = ex(4'h7, 4'h0, 4'hF, 4'hF, 64'd64, 64'd209, 1, 1);
    pcs[4] = 64'd220; ws[4] = 80'h80112233445566778899; xs[4] = ex(4'h8, 4'h0, 4'hF, 4'hF, 64'h1122334455667788, 64'd229, 1, 1);
    pcs[5] = 64'd240; ws[5] = 80'h9012345678901234567A; xs[5] = ex(4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd241, 1, 1);
    for (int i = 0; i < 6; i++) begin
      drive(pcs[i], ws[i]);
      total++;
      if (obs() !== xs[i]) begin bad++; $display("FAIL stack_jump%0d got=%h want=%h", i, obs(), xs[i]); end
    end
  endtask

  function automatic logic [79:0] prog(input logic [63:0] pc);
    case (pc)
      64'd64:  return 80'h20230000000000000000;
      64'd66:  return 80'h30F3000000000000001F;
      64'd76:  return 80'h40240000000000000005;
      64'd86:  return 80'h50240000000000000004;
      64'd96:  return 80'h63240000000000000000;
      64'd98:  return 80'hA12F0000000000000000;
      64'd100: return 80'hB12F0000000000000000;
      64'd102: return 80'h10000000000000000000;
      default: return 80'h00000000000000000000;
    endcase
  endfunction

  task automatic test_sequence();
    logic [63:0] seq[9];
    logic [63:0] nv;
    seq = '{64'd64, 64'd66, 64'd76, 64'd86, 64'd96, 64'd98, 64'd100, 64'd102, 64'd103};
    @(negedge clk);
    PC = 64'd64;
    for (int i = 0; i < 9; i++) begin
      instruction = prog(PC);
      #1;
      total++;
      if (PC !== seq[i]) begin bad++; $display("FAIL seq_pc%0d got=%0d want=%0d", i, PC, seq[i]); end
      if (i < 8) begin
        nv = valP;
        @(posedge clk);
        #1;
        PC = nv;
      end
    end
    total++;
    if (valP !== 64'd103 || halted !== 1'b0) begin bad++; $display("FAIL halt_stall got valP=%0d halted=%b want valP=103 halted=0", valP, halted); end
    @(posedge clk);
    #1;
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b want=1", halted); end
    drive(64'd64, 80'h20230000000000000000);
    total++;
    if (valP !== 64'd64) begin bad++; $display("FAIL halted_stall got=%0d want=64", valP); end
    @(posedge clk);
    #1;
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b want=1", halted); end
    reset = 1'b1;
    #1;
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL async_reset got=%b want=0", halted); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (halted !== 1'b0 || valP !== 64'd66) begin bad++; $display("FAIL post_reset got halted=%b valP=%0d want halted=0 valP=66", halted, valP); end
  endtask

  task automatic test_illegal();
    logic [79:0]  ws[5];
    logic [145:0] xs[5];
    ws[0] = 80'hC0000000000000000000; xs[0] = ex(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd300, 1, 0);
    ws[1] = 80'h27000000000000000000; xs[1] = ex(4'h2, 4'h7, 4'h0, 4'h0, 64'd0, 64'd300, 1, 0);
    ws[2] = 80'h64000000000000000000; xs[2] = ex(4'h6, 4'h4, 4'h0, 4'h0, 64'd0, 64'd300, 1, 0);
    ws[3] = 80'h77000000000000000000; xs[3] = ex(4'h7, 4'h7, 4'hF, 4'hF, 64'h0000000000000000, 64'd300, 1, 0);
    ws[4] = 80'h76000000000000000100; xs[4] = ex(4'h7, 4'h6, 4'hF, 4'hF, 64'd1, 64'd309, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(64'd300, ws[i]);
      total++;
      if (obs() !== xs[i]) begin bad++; $display("FAIL illegal%0d got=%h want=%h", i, obs(), xs[i]); end
    end
  endtask

  task automatic test_out_of_range();
    drive(64'd65535, 80'h20230000000000000000);
    total++;
    if (obs() !== ex(4'h2, 4'h0, 4'h2, 4'h3, 64'd0, 64'd65537, 1, 1)) begin bad++; $display("FAIL last_addr got=%h", obs()); end
    drive(64'd65536, 80'h20230000000000000000);
    total++;
    if (obs() !== ex(4'h2, 4'h0, 4'h2, 4'h3, 64'd0, 64'd65536, 0, 0)) begin bad++; $display("FAIL oob got=%h", obs()); end
    drive(64'd65536, 80'h00000000000000000000);
    @(posedge clk);
    #1;
    total++;
    if (halted !== 1'b0 || valP !== 64'd65536) begin bad++; $display("FAIL oob_halt got halted=%b valP=%0d want halted=0 valP=65536", halted, valP); end
  endtask

  initial begin
    test_reset();
    test_reg_ops();
    test_const_ops();
    test_stack_jump();
    test_illegal();
    test_out_of_range();
    test_sequence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
